and_unit: RTL and testbench
===========================

// Module: and_unit
// PURPOSE
//  - Bitwise-AND functional unit of the 8-bit single-cycle processor ALU.
//  - Combinational result = data1 & data2, consumed by the ALU result mux in the same cycle.
//  - Also provides a registered copy of the result and a zero flag for the ALU status path.
// PARAMETERS
//  - WIDTH  8  operand/result width in bits; the processor uses 8.
// PORTS
//  - clk         input   1      system clock; one clock domain, rising-edge.
//  - reset       input   1      asynchronous, active-high reset.
//  - data1       input   WIDTH  operand A; two's-complement signed, treated as a raw bit vector.
//  - data2       input   WIDTH  operand B; two's-complement signed, treated as a raw bit vector.
//  - result      output  WIDTH  combinational data1 & data2.
//  - zero        output  1      combinational; 1 when result == 0.
//  - result_reg  output  WIDTH  result captured on the rising edge of clk.
//  - zero_reg    output  1      zero captured on the rising edge of clk.
// BEHAVIOUR
//  - result[i] = data1[i] & data2[i] for every i in 0..WIDTH-1.
//    - Pure bitwise operation: no sign extension, carry or overflow.
//    - Signedness of the operands has no effect on result.
//  - result and zero have zero-cycle latency and no modelled delay.
//    - Both settle within the same time step as any operand change.
//    - Neither is affected by clk or reset.
//  - The combinational outputs must never produce X or Z for known (non-X) inputs.
//  - result_reg/zero_reg: updated on every rising clk edge with the current result/zero. No enable.
//  - Reset behaviour:
//    - When reset asserts, result_reg = 0 and zero_reg = 1 immediately, without waiting for a clock edge.
//    - The registers hold these values while reset is high.
//  - Reset release: the first rising clk edge after reset deasserts loads the live result.
//  - Reset mid-operation: the registered outputs clear at once; result/zero keep tracking the inputs.
//  - Operand change on a clock edge: the register captures the value that was settled before the edge.
//  - Boundary cases:
//    - all-ones & x = x.
//    - 0 & x = 0, which sets zero = 1.
//    - 0x80 & 0x80 = 0x80, so zero = 0 (the sign bit alone is non-zero).
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - the constant ALU_WIDTH = 8;
//    - the ALU opcode constants (AND select code included), used by the ALU mux, not by this block.
//  - One natural sub-module, and_reg: a WIDTH+1-bit register with asynchronous active-high reset.
//    - Reset value is {WIDTH'b0, 1'b1} so that zero_reg resets to 1.
//    - It holds {result, zero}.
//  - The AND datapath is inline: a vector AND or a per-bit generate loop.
// TESTING
//  - Operands are applied at 1-time-unit spacing and the combinational outputs are checked after each step.
//    - 25 & 3 (00011001 & 00000011) -> result = 00000001 (1), zero = 0.
//    - 1 & 8 (00000001 & 00001000) -> result = 00000000, zero = 1.
//    - 2 & -5 (00000010 & 11111011) -> result = 00000010 (2), zero = 0.
//    - 6 & -2 (00000110 & 11111110) -> result = 00000110 (6), zero = 0.
//  - Registered path:
//    - Hold reset high with operands 0xFF & 0x5A -> result = 0x5A combinationally; result_reg = 0x00 and zero_reg = 1 throughout.
//    - Release reset -> the next rising edge gives result_reg = 0x5A, zero_reg = 0.
//    - Assert reset mid-cycle, between clock edges -> result_reg = 0 and zero_reg = 1 at once; result unchanged.
//  - Exhaustive sweep: all 65536 operand pairs at WIDTH = 8.
//    - result equals the reference data1 & data2.
//    - zero == (result == 0).
//    - No X on any output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and opcode select codes.
// The opcodes drive the ALU result mux; individual functional units ignore them.
`timescale 1ns/1ps
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;
  localparam int unsigned ALU_OP_W  = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OP_ADD = 3'd0,
    ALU_OP_SUB = 3'd1,
    ALU_OP_AND = 3'd2,
    ALU_OP_OR  = 3'd3,
    ALU_OP_XOR = 3'd4,
    ALU_OP_SLT = 3'd5,
    ALU_OP_SHL = 3'd6,
    ALU_OP_SHR = 3'd7
  } alu_op_e;

endpackage

// File: rtl/and_reg.sv
// WIDTH+1-bit status register holding {result, zero}; async active-high reset.
// The reset value has the low bit set so the registered zero flag reads 1 out of reset.
`timescale 1ns/1ps
module and_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [WIDTH:0] d,
  output logic [WIDTH:0] q
);

  localparam logic [WIDTH:0] RST_VAL = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] data_d;
  logic [WIDTH:0] data_q;

  always_comb begin
    data_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/and_unit.sv
// Bitwise-AND functional unit: combinational result/zero plus a registered copy
// of both for the ALU status path.
`timescale 1ns/1ps
module and_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] result_reg,
  output logic             zero_reg
);

  logic [WIDTH:0] status_d;
  logic [WIDTH:0] status_q;

  always_comb begin
    result   = data1 & data2;
    zero     = ~|result;
    status_d = {result, zero};
  end

  and_reg #(
    .WIDTH(WIDTH)
  ) u_and_reg (
    .clk  (clk),
    .reset(reset),
    .d    (status_d),
    .q    (status_q)
  );

  assign result_reg = status_q[WIDTH:1];
  assign zero_reg   = status_q[0];

endmodule

// File: tb/tb_and_unit.sv
// Directed and exhaustive checks of and_unit: combinational AND/zero and the registered path.
`timescale 1ns/1ps
module tb_and_unit;

  logic       clk;
  logic       reset;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] result;
  logic       zero;
  logic [7:0] result_reg;
  logic       zero_reg;

  int unsigned passed;
  int unsigned total;

  and_unit #(
    .WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data1     (data1),
    .data2     (data2),
    .result    (result),
    .zero      (zero),
    .result_reg(result_reg),
    .zero_reg  (zero_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    data1 = 8'hFF;
    data2 = 8'h5A;
    reset = 1'b1;
    #1;
    for (int unsigned c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (result !== 8'h5A || zero !== 1'b0)
        $display("FAIL reset_comb c%0d: result=%h zero=%b want 5a 0", c, result, zero);
      else passed++;
      total++;
      if (result_reg !== 8'h00 || zero_reg !== 1'b1)
        $display("FAIL reset_hold c%0d: result_reg=%h zero_reg=%b want 00 1", c, result_reg, zero_reg);
      else passed++;
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (result_reg !== 8'h00 || zero_reg !== 1'b1)
      $display("FAIL release_pre_edge: result_reg=%h zero_reg=%b want 00 1", result_reg, zero_reg);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (result_reg !== 8'h5A || zero_reg !== 1'b0)
      $display("FAIL release_load: result_reg=%h zero_reg=%b want 5a 0", result_reg, zero_reg);
    else passed++;
  endtask

  task automatic test_comb_vectors();
    logic [7:0] a   [4] = '{8'd25, 8'd1, 8'd2, 8'd6};
    logic [7:0] b   [4] = '{8'd3, 8'd8, 8'hFB, 8'hFE};
    logic [7:0] exp [4] = '{8'd1, 8'd0, 8'd2, 8'd6};
    logic       expz[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int unsigned i = 0; i < 4; i++) begin
      data1 = a[i];
      data2 = b[i];
      #1;
      total++;
      if (result !== exp[i] || zero !== expz[i])
        $display("FAIL comb_vec%0d: result=%h zero=%b want %h %b", i, result, zero, exp[i], expz[i]);
      else passed++;
    end
  endtask

  // Each vector is applied between edges and checked after the following rising edge.
  task automatic test_back_to_back();
    logic [7:0] a   [5] = '{8'hFF, 8'h00, 8'h80, 8'h3C, 8'hA5};
    logic [7:0] b   [5] = '{8'hC3, 8'h77, 8'h80, 8'hC3, 8'hFF};
    logic [7:0] exp [5] = '{8'hC3, 8'h00, 8'h80, 8'h00, 8'hA5};
    logic       expz[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      data1 = a[i];
      data2 = b[i];
      #1;
      total++;
      if (result !== exp[i] || zero !== expz[i])
        $display("FAIL b2b_comb%0d: result=%h zero=%b want %h %b", i, result, zero, exp[i], expz[i]);
      else passed++;
      @(posedge clk);
      #1;
      data1 = ~a[i];
      data2 = 8'hFF;
      #1;
      total++;
      if (result_reg !== exp[i] || zero_reg !== expz[i])
        $display("FAIL b2b_reg%0d: result_reg=%h zero_reg=%b want %h %b", i, result_reg, zero_reg, exp[i], expz[i]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    data1 = 8'hFF;
    data2 = 8'h5A;
    @(posedge clk);
    #1;
    total++;
    if (result_reg !== 8'h5A || zero_reg !== 1'b0)
      $display("FAIL mid_preload: result_reg=%h zero_reg=%b want 5a 0", result_reg, zero_reg);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (result_reg !== 8'h00 || zero_reg !== 1'b1)
      $display("FAIL mid_reset_async: result_reg=%h zero_reg=%b want 00 1", result_reg, zero_reg);
    else passed++;
    total++;
    if (result !== 8'h5A || zero !== 1'b0)
      $display("FAIL mid_reset_comb: result=%h zero=%b want 5a 0", result, zero);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (result_reg !== 8'h00 || zero_reg !== 1'b1)
      $display("FAIL mid_reset_hold: result_reg=%h zero_reg=%b want 00 1", result_reg, zero_reg);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (result_reg !== 8'h5A || zero_reg !== 1'b0)
      $display("FAIL mid_reset_release: result_reg=%h zero_reg=%b want 5a 0", result_reg, zero_reg);
    else passed++;
  endtask

  task automatic test_sweep();
    int unsigned errs;
    logic [7:0]  ref_r;
    errs = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      for (int unsigned j = 0; j < 256; j++) begin
        data1 = i[7:0];
        data2 = j[7:0];
        #1;
        ref_r = i[7:0] & j[7:0];
        total++;
        if ($isunknown({result, zero, result_reg, zero_reg}) || result !== ref_r ||
            zero !== (ref_r == 8'h00)) begin
          if (errs < 8)
            $display("FAIL sweep %h&%h: result=%h zero=%b want %h %b",
                     i[7:0], j[7:0], result, zero, ref_r, (ref_r == 8'h00));
          errs++;
        end else passed++;
      end
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    data1  = '0;
    data2  = '0;
    test_reset();
    test_release();
    test_comb_vectors();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
